// File: rtl/view_port_loader.sv
// view_port_loader: streams an LC-3 object image (origin, count, data words,
// big-endian bytes) into memory through the view port and holds the CPU off
// via Busy while loading.
// Build option: define LOADER_VERIFY_EN to read back and compare each word
// after it is written.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | after reset, waiting for Start
// HDR_ORIG | collecting the two origin bytes
// HDR_LEN  | collecting the two word-count bytes
// DATA     | collecting the two bytes of the next data word
// WRITE    | one-cycle View_WE pulse for the assembled word
// VERIFY   | read-back of the just-written word (LOADER_VERIFY_EN only)
// DONE     | load complete, waiting for Start
// ERR      | timeout or read-back mismatch, waiting for Start
module view_port_loader #(
  parameter int          READ_LATENCY = 1,
  parameter logic [15:0] TIMEOUT      = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  Byte_In,
  input  logic        Byte_Valid,
  output logic        Byte_Ready,
  output logic [15:0] View_Address,
  output logic [15:0] View_Data,
  output logic        View_WE,
  input  logic [15:0] View_Out,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [15:0] Words_Written
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_ORIG,
    S_HDR_LEN,
    S_DATA,
    S_WRITE,
`ifdef LOADER_VERIFY_EN
    S_VERIFY,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;   // 0: expecting high byte
  logic [7:0]  hi_q, hi_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic [15:0] words_q, words_d;
  logic [15:0] tmo_q, tmo_d;       // down-counter, expires on terminal count 1

  logic        byte_ready;
  logic        acc;
  logic        word_done;
  logic [15:0] word;

`ifdef LOADER_VERIFY_EN
  localparam logic [7:0] RD_LAT = 8'(READ_LATENCY);
  logic [7:0] lat_q, lat_d;
`else
  logic unused_view_out;
  assign unused_view_out = ^{View_Out, 8'(READ_LATENCY)};
`endif

  assign byte_ready = (state_q == S_HDR_ORIG) || (state_q == S_HDR_LEN) ||
                      (state_q == S_DATA);
  assign acc        = Byte_Valid && byte_ready;
  assign word_done  = acc && phase_q;
  assign word       = {hi_q, Byte_In};

  // Next-state, byte assembly and timeout logic
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    words_d = words_q;
    tmo_d   = tmo_q;
`ifdef LOADER_VERIFY_EN
    lat_d   = lat_q;
`endif

    if (acc) begin
      phase_d = ~phase_q;
      if (!phase_q) hi_d = Byte_In;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) begin
          state_d = S_HDR_ORIG;
          words_d = 16'd0;
          phase_d = 1'b0;
          tmo_d   = TIMEOUT;
        end
      end
      S_HDR_ORIG: begin
        if (word_done) begin
          addr_d  = word;
          state_d = S_HDR_LEN;
        end
      end
      S_HDR_LEN: begin
        if (word_done) begin
          cnt_d   = word;
          state_d = (word == 16'd0) ? S_DONE : S_DATA;
        end
      end
      S_DATA: begin
        if (word_done) begin
          data_d  = word;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 16'd1;
        cnt_d   = cnt_q - 16'd1;
        words_d = words_q + 16'd1;
`ifdef LOADER_VERIFY_EN
        lat_d   = 8'd0;
        state_d = S_VERIFY;
`else
        state_d = (cnt_q == 16'd1) ? S_DONE : S_DATA;
`endif
      end
`ifdef LOADER_VERIFY_EN
      S_VERIFY: begin
        if (lat_q == RD_LAT) begin
          if (View_Out != data_q) state_d = S_ERR;
          else                    state_d = (cnt_q == 16'd0) ? S_DONE : S_DATA;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Inter-byte timeout; an expiry drops any half-assembled word
    if (byte_ready) begin
      if (acc) begin
        tmo_d = TIMEOUT;
      end else if (TIMEOUT != 16'd0) begin
        if (tmo_q <= 16'd1) begin
          state_d = S_ERR;
          phase_d = 1'b0;
        end else begin
          tmo_d = tmo_q - 16'd1;
        end
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      hi_q    <= 8'd0;
      addr_q  <= 16'd0;
      cnt_q   <= 16'd0;
      data_q  <= 16'd0;
      words_q <= 16'd0;
      tmo_q   <= 16'd0;
`ifdef LOADER_VERIFY_EN
      lat_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      words_q <= words_d;
      tmo_q   <= tmo_d;
`ifdef LOADER_VERIFY_EN
      lat_q   <= lat_d;
`endif
    end
  end

  // Output decode; VERIFY shows the pre-increment address
  always_comb begin
    Byte_Ready    = byte_ready;
    View_WE       = (state_q == S_WRITE);
    View_Data     = data_q;
    Words_Written = words_q;
    Done          = (state_q == S_DONE);
    Error         = (state_q == S_ERR);
    Busy          = !((state_q == S_IDLE) || (state_q == S_DONE) ||
                      (state_q == S_ERR));
    View_Address  = (state_q == S_IDLE) ? 16'd0 : addr_q;
`ifdef LOADER_VERIFY_EN
    if (state_q == S_VERIFY) View_Address = addr_q - 16'd1;
`endif
  end

endmodule

// File: tb/tb_view_port_loader.sv
// Directed bench for view_port_loader with a synchronous read-first memory
// model on the view port (one cycle read latency).
module tb_view_port_loader;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [7:0]  Byte_In;
  logic        Byte_Valid;
  logic        Byte_Ready;
  logic [15:0] View_Address;
  logic [15:0] View_Data;
  logic        View_WE;
  logic [15:0] View_Out;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [15:0] Words_Written;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:65535];
  logic        corrupt_en = 1'b0;
  int          we_count   = 0;
  int          we_double  = 0;
  logic        prev_we    = 1'b0;
  logic [15:0] wr_addr [$];

  view_port_loader #(.READ_LATENCY(1), .TIMEOUT(16'd8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Byte_In(Byte_In),
    .Byte_Valid(Byte_Valid), .Byte_Ready(Byte_Ready),
    .View_Address(View_Address), .View_Data(View_Data), .View_WE(View_WE),
    .View_Out(View_Out), .Busy(Busy), .Done(Done), .Error(Error),
    .Words_Written(Words_Written)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // memory model: synchronous write, registered read-first output
  always @(posedge Clk) begin
    View_Out <= mem[View_Address] ^
                {15'd0, corrupt_en && (View_Address == 16'h3001)};
    if (View_WE) begin
      mem[View_Address] <= View_Data;
      we_count++;
      wr_addr.push_back(View_Address);
      if (prev_we) we_double++;
    end
    prev_we <= View_WE;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    Byte_In    = b;
    Byte_Valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (Byte_Ready) begin
        tick();
        got = 1'b1;
        break;
      end
      tick();
    end
    Byte_Valid = 1'b0;
    check("byte_accept", {31'd0, got}, 32'd1);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_end();
    bit fin;
    fin = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (Done || Error) begin
        fin = 1'b1;
        break;
      end
      tick();
    end
    check("wait_end", {31'd0, fin}, 32'd1);
  endtask

  int we_base;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    Reset = 1'b0; Start = 1'b0; Byte_In = 8'h00; Byte_Valid = 1'b0;
    #2;
    // reset state
    check("rst_busy",  {31'd0, Busy}, 32'd0);
    check("rst_done",  {31'd0, Done}, 32'd0);
    check("rst_error", {31'd0, Error}, 32'd0);
    check("rst_ready", {31'd0, Byte_Ready}, 32'd0);
    check("rst_we",    {31'd0, View_WE}, 32'd0);
    check("rst_addr",  {16'd0, View_Address}, 32'h0);
    check("rst_words", {16'd0, Words_Written}, 32'h0);
    tick(); tick();
    Reset = 1'b1;
    tick();
    check("idle_ready", {31'd0, Byte_Ready}, 32'd0);

    // basic two-word load
    pulse_start();
    check("t1_busy",  {31'd0, Busy}, 32'd1);
    check("t1_ready", {31'd0, Byte_Ready}, 32'd1);
    send_byte(8'h30); send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34);
    check("t1_we0_addr", {16'd0, View_Address}, 32'h3000);
    check("t1_we0",      {31'd0, View_WE}, 32'd1);
    send_byte(8'hAB); send_byte(8'hCD);
    check("t1_we1",      {31'd0, View_WE}, 32'd1);
    check("t1_we1_addr", {16'd0, View_Address}, 32'h3001);
    check("t1_we1_data", {16'd0, View_Data}, 32'hABCD);
    check("t1_ready_wr", {31'd0, Byte_Ready}, 32'd0);
    wait_end();
    check("t1_done",   {31'd0, Done}, 32'd1);
    check("t1_busy0",  {31'd0, Busy}, 32'd0);
    check("t1_words",  {16'd0, Words_Written}, 32'd2);
    check("t1_mem0",   {16'd0, mem[16'h3000]}, 32'h1234);
    check("t1_mem1",   {16'd0, mem[16'h3001]}, 32'hABCD);
    check("t1_wecnt",  we_count, 32'd2);
    check("t1_we_1cyc", we_double, 32'd0);

    // address wrap
    pulse_start();
    check("t2_done_clr",  {31'd0, Done}, 32'd0);
    check("t2_words_clr", {16'd0, Words_Written}, 32'd0);
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
    wait_end();
    check("t2_done",  {31'd0, Done}, 32'd1);
    check("t2_words", {16'd0, Words_Written}, 32'd2);
    check("t2_addr0", {16'd0, wr_addr[2]}, 32'hFFFF);
    check("t2_addr1", {16'd0, wr_addr[3]}, 32'h0000);
    check("t2_memF",  {16'd0, mem[16'hFFFF]}, 32'h0001);
    check("t2_mem0",  {16'd0, mem[16'h0000]}, 32'h0002);

    // zero-length image
    we_base = we_count;
    pulse_start();
    send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("t3_done",  {31'd0, Done}, 32'd1);
    check("t3_busy",  {31'd0, Busy}, 32'd0);
    check("t3_words", {16'd0, Words_Written}, 32'd0);
    tick();
    check("t3_nowe",  we_count - we_base, 32'd0);

    // timeout after three bytes (TIMEOUT = 8)
    we_base = we_count;
    pulse_start();
    send_byte(8'h50); send_byte(8'h00); send_byte(8'h00);
    for (int i = 0; i < 7; i++) tick();
    check("t4_err_early", {31'd0, Error}, 32'd0);
    check("t4_busy_early", {31'd0, Busy}, 32'd1);
    tick();
    check("t4_err",   {31'd0, Error}, 32'd1);
    check("t4_busy0", {31'd0, Busy}, 32'd0);
    check("t4_done0", {31'd0, Done}, 32'd0);
    check("t4_nowe",  we_count - we_base, 32'd0);
    pulse_start();
    check("t4_err_clr", {31'd0, Error}, 32'd0);
    send_byte(8'h60); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hBE); send_byte(8'hEF);
    wait_end();
    check("t4_done",  {31'd0, Done}, 32'd1);
    check("t4_words", {16'd0, Words_Written}, 32'd1);
    check("t4_mem",   {16'd0, mem[16'h6000]}, 32'hBEEF);

    // Start while busy is ignored, then reset mid-load
    pulse_start();
    send_byte(8'h70); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h11);
    tick();
    pulse_start();
    check("t5_busy", {31'd0, Busy}, 32'd1);
    check("t5_words_held", {16'd0, Words_Written}, 32'd1);
    send_byte(8'h22); send_byte(8'h22);
    check("t5_addr2", {16'd0, View_Address}, 32'h7001);
    tick();
    check("t5_words2", {16'd0, Words_Written}, 32'd2);
    Reset = 1'b0;
    #1;
    check("t5_rst_busy",  {31'd0, Busy}, 32'd0);
    check("t5_rst_ready", {31'd0, Byte_Ready}, 32'd0);
    check("t5_rst_we",    {31'd0, View_WE}, 32'd0);
    check("t5_rst_addr",  {16'd0, View_Address}, 32'h0);
    check("t5_rst_data",  {16'd0, View_Data}, 32'h0);
    check("t5_rst_words", {16'd0, Words_Written}, 32'h0);
    check("t5_mem_kept",  {16'd0, mem[16'h7000]}, 32'h1111);
    tick();
    Reset = 1'b1;
    tick();

`ifdef LOADER_VERIFY_EN
    // read-back mismatch on the second word
    corrupt_en = 1'b1;
    pulse_start();
    send_byte(8'h30); send_byte(8'h00); send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
    wait_end();
    check("t6_err",   {31'd0, Error}, 32'd1);
    check("t6_done0", {31'd0, Done}, 32'd0);
    check("t6_words", {16'd0, Words_Written}, 32'd2);
    corrupt_en = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/view_port_loader.md
Name: view_port_loader

Overview:
- Program loader that drives the memory block's view port (View_Address/View_Data/View_WE, reads View_Out). It is the master side of the port the memory subsystem exposes as a slave.
- Consumes an LC-3 object image as a byte stream (valid/ready, big-endian words): word 0 = origin, word 1 = word count N, then N data words.
- Writes the data words to consecutive addresses and holds the CPU off while loading.
- Runs on the same clock fed to Clk_View.

Parameters:
- READ_LATENCY, 1, cycles from View_Address to valid View_Out (used by verify only).
- TIMEOUT, 16'hFFFF, idle cycles allowed between accepted bytes while Busy before abort; 0 disables the timeout.

Ports:
- Clk  in  1  clock, also drives memory Clk_View.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse; arms the loader.
- Byte_In  in  8  stream byte.
- Byte_Valid  in  1  Byte_In valid.
- Byte_Ready  out  1  loader accepts byte this cycle.
- View_Address  out  16  memory view address.
- View_Data  out  16  memory view write data.
- View_WE  out  1  memory view write enable.
- View_Out  in  16  memory view read data.
- Busy  out  1  load in progress; also CPU hold.
- Done  out  1  sticky, load completed.
- Error  out  1  sticky, timeout or verify mismatch.
- Words_Written  out  16  count of data words written this load.

Behaviour:
- Reset (Reset=0, async): all outputs 0, state IDLE, byte phase = high.
- Byte transfer occurs only when Byte_Valid && Byte_Ready at the rising edge. Each word is assembled as first byte = [15:8], second byte = [7:0].
- IDLE: Byte_Ready=0. On Start: clear Done, Error, Words_Written; set Busy=1; go to HDR_ORIG. Start is ignored in every state except IDLE, DONE and ERR.
- HDR_ORIG: Byte_Ready=1; after 2 bytes, latch the address register and go to HDR_LEN.
- HDR_LEN: Byte_Ready=1; after 2 bytes, latch the count register.
  - Count = 0: go to DONE on the next edge.
  - Otherwise: go to DATA.
- DATA: Byte_Ready=1; after the low byte, latch View_Data and go to WRITE.
- WRITE: exactly one cycle with View_WE=1, View_Address=addr, and Byte_Ready=0.
  - On exit: addr <= addr+1 (16-bit wrap, 16'hFFFF -> 16'h0000), count <= count-1, Words_Written <= Words_Written+1.
  - Next state: VERIFY when the feature is enabled; else DONE if the new count is 0; else DATA.
- View_Address shows addr in every non-IDLE state. View_WE=0 everywhere except WRITE.
- DONE: Busy=0, Done=1, Byte_Ready=0. Held until Start.
- ERR: Busy=0, Error=1, Done=0, Byte_Ready=0. Held until Start.
- Timeout: a counter clears on each accepted byte and on entering HDR_ORIG.
  - It counts cycles in HDR_ORIG, HDR_LEN and DATA.
  - When it reaches TIMEOUT (TIMEOUT≠0), go to ERR; any partial word is discarded.
- Reset mid-load: abort immediately; memory keeps the words already written.
- Words_Written and count are 16 bits wide; N=16'hFFFF is legal.

Optional Feature:
- Macro: LOADER_VERIFY_EN.
- Defined: add a VERIFY state after WRITE.
  - View_WE=0 and View_Address holds the just-written address (pre-increment) for READ_LATENCY cycles, then View_Out is compared with View_Data.
  - Mismatch: go to ERR. Match: go to DATA, or to DONE if count is 0.
  - Byte_Ready=0 throughout VERIFY.
- Undefined: no VERIFY state, View_Out is unused, and WRITE goes directly to DATA/DONE.

Test Plan:
- Reset, Start, bytes 30 00 00 02 12 34 AB CD → writes 16'h3000=16'h1234 and 16'h3001=16'hABCD; each write has View_WE high exactly 1 cycle; Done=1, Busy=0, Words_Written=2.
- Origin FFFF, count 0002, data 0001 0002 → writes to FFFF then 0000 (wrap); Done=1.
- Count 0000 → no View_WE pulse; Done=1 one cycle after the 4th header byte; Words_Written=0.
- TIMEOUT=8; Byte_Valid stalls after 3 bytes → Error=1 after 8 idle cycles, no write; a new Start clears Error and loads normally.
- Reset pulsed low after the first data word is written → all outputs 0 immediately; memory word 0 retained. Start pulsed while Busy is ignored.
- LOADER_VERIFY_EN with the memory model corrupting bit 0 of address 3001 → Error=1 after the second write, Words_Written=2, Done=0.
